// File: rtl/decode_control.sv
// RV32I decode: immediate extraction plus control-signal generation.
// Ports: clk, reset_n, ins in; imm, imm_type, alu/mem/pc controls, op_illegal out.
module decode_control (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] ins,
  output logic [31:0] imm,
  output logic [2:0]  imm_type,
  output logic        op_illegal,
  output logic        alu_imm,
  output logic        alu_a0,
  output logic        alu_apc,
  output logic        alu_b4,
  output logic [2:0]  alu_op,
  output logic        alu_alt,
  output logic        reg_wen,
  output logic        dmem_write,
  output logic        dmem_read,
  output logic        dmem_reg,
  output logic [2:0]  pc_imm
);

  localparam logic [2:0] IT_NONE = 3'd0;
  localparam logic [2:0] IT_I    = 3'd1;
  localparam logic [2:0] IT_S    = 3'd2;
  localparam logic [2:0] IT_B    = 3'd3;
  localparam logic [2:0] IT_U    = 3'd4;
  localparam logic [2:0] IT_J    = 3'd5;

  localparam logic [2:0] PC_0    = 3'd0;
  localparam logic [2:0] PC_4    = 3'd1;
  localparam logic [2:0] PC_BNZ  = 3'd2;
  localparam logic [2:0] PC_BZ   = 3'd3;
  localparam logic [2:0] PC_JAL  = 3'd4;
  localparam logic [2:0] PC_JALR = 3'd5;

  localparam logic [6:0] OPC_OP   = 7'b0110011;
  localparam logic [6:0] OPC_OPI  = 7'b0010011;
  localparam logic [6:0] OPC_LD   = 7'b0000011;
  localparam logic [6:0] OPC_ST   = 7'b0100011;
  localparam logic [6:0] OPC_BR   = 7'b1100011;
  localparam logic [6:0] OPC_LUI  = 7'b0110111;
  localparam logic [6:0] OPC_AUI  = 7'b0010111;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [6:0] OPC_MISC = 7'b0001111;

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       ill;

  assign opc = ins[6:0];
  assign f3  = ins[14:12];
  assign f7  = ins[31:25];

  always_comb begin
    imm_type = IT_NONE;
    unique case (opc)
      OPC_OPI, OPC_LD, OPC_JALR: imm_type = IT_I;
      OPC_ST:                    imm_type = IT_S;
      OPC_BR:                    imm_type = IT_B;
      OPC_LUI, OPC_AUI:          imm_type = IT_U;
      OPC_JAL:                   imm_type = IT_J;
      default:                   imm_type = IT_NONE;
    endcase
  end

  always_comb begin
    imm = 32'h0;
    unique case (imm_type)
      IT_I: imm = {{20{ins[31]}}, ins[31:20]};
      IT_S: imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IT_B: imm = {{19{ins[31]}}, ins[31], ins[7],
                   ins[30:25], ins[11:8], 1'b0};
      IT_U: imm = {ins[31:12], 12'h0};
      IT_J: imm = {{11{ins[31]}}, ins[31], ins[19:12],
                   ins[20], ins[30:21], 1'b0};
      default: imm = 32'h0;
    endcase
  end

  always_comb begin
    ill        = 1'b0;
    alu_imm    = 1'b0;
    alu_a0     = 1'b0;
    alu_apc    = 1'b0;
    alu_b4     = 1'b0;
    alu_op     = 3'b000;
    alu_alt    = 1'b0;
    reg_wen    = 1'b0;
    dmem_write = 1'b0;
    dmem_read  = 1'b0;
    dmem_reg   = 1'b0;
    pc_imm     = PC_4;
    unique case (opc)
      OPC_OP: begin
        alu_op  = f3;
        alu_alt = ins[30];
        reg_wen = 1'b1;
        ill = !((f7 == 7'h00) ||
                (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
      end
      OPC_OPI: begin
        alu_op  = f3;
        alu_imm = 1'b1;
        reg_wen = 1'b1;
        alu_alt = (f3 == 3'b101) ? ins[30] : 1'b0;
        if (f3 == 3'b001)
          ill = (f7 != 7'h00);
        else if (f3 == 3'b101)
          ill = !(f7 == 7'h00 || f7 == 7'h20);
      end
      OPC_LD: begin
        alu_imm   = 1'b1;
        dmem_read = 1'b1;
        dmem_reg  = 1'b1;
        reg_wen   = 1'b1;
        ill = (f3 == 3'b011) || (f3[2:1] == 2'b11);
      end
      OPC_ST: begin
        alu_imm    = 1'b1;
        dmem_write = 1'b1;
        ill = (f3 >= 3'b011);
      end
      OPC_BR: begin
        unique case (f3)
          3'b000: begin alu_alt = 1'b1; pc_imm = PC_BZ;  end
          3'b001: begin alu_alt = 1'b1; pc_imm = PC_BNZ; end
          3'b100: begin alu_op = 3'b010; pc_imm = PC_BNZ; end
          3'b101: begin alu_op = 3'b010; pc_imm = PC_BZ;  end
          3'b110: begin alu_op = 3'b011; pc_imm = PC_BNZ; end
          3'b111: begin alu_op = 3'b011; pc_imm = PC_BZ;  end
          default: ill = 1'b1;
        endcase
      end
      OPC_LUI: begin
        alu_a0  = 1'b1;
        alu_imm = 1'b1;
        reg_wen = 1'b1;
      end
      OPC_AUI: begin
        alu_apc = 1'b1;
        alu_imm = 1'b1;
        reg_wen = 1'b1;
      end
      OPC_JAL: begin
        alu_apc = 1'b1;
        alu_b4  = 1'b1;
        reg_wen = 1'b1;
        pc_imm  = PC_JAL;
      end
      OPC_JALR: begin
        alu_apc = 1'b1;
        alu_b4  = 1'b1;
        reg_wen = 1'b1;
        pc_imm  = PC_JALR;
        ill = (f3 != 3'b000);
      end
      OPC_MISC: ;
      default: ill = 1'b1;
    endcase
    // An illegal word must not change architectural state.
    if (ill) begin
      alu_imm    = 1'b0;
      alu_a0     = 1'b0;
      alu_apc    = 1'b0;
      alu_b4     = 1'b0;
      alu_op     = 3'b000;
      alu_alt    = 1'b0;
      reg_wen    = 1'b0;
      dmem_write = 1'b0;
      dmem_read  = 1'b0;
      dmem_reg   = 1'b0;
      pc_imm     = PC_0;
    end
    // Reset keeps the fetch stream advancing with no side effects.
    if (!reset_n) begin
      reg_wen    = 1'b0;
      dmem_write = 1'b0;
      dmem_read  = 1'b0;
      dmem_reg   = 1'b0;
      pc_imm     = PC_4;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      op_illegal <= 1'b0;
    else if (ill)
      op_illegal <= 1'b1;
  end

endmodule

// File: tb/tb_decode_control.sv
// Directed-vector bench for decode_control.
// Table of {ins, expected outputs} plus sticky-flag and reset sequences.
module tb_decode_control;

  logic        clk;
  logic        reset_n;
  logic [31:0] ins;
  logic [31:0] imm;
  logic [2:0]  imm_type;
  logic        op_illegal;
  logic        alu_imm, alu_a0, alu_apc, alu_b4;
  logic [2:0]  alu_op;
  logic        alu_alt;
  logic        reg_wen, dmem_write, dmem_read, dmem_reg;
  logic [2:0]  pc_imm;

  int checks = 0;
  int passed = 0;
  logic sticky;

  decode_control dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ins        (ins),
    .imm        (imm),
    .imm_type   (imm_type),
    .op_illegal (op_illegal),
    .alu_imm    (alu_imm),
    .alu_a0     (alu_a0),
    .alu_apc    (alu_apc),
    .alu_b4     (alu_b4),
    .alu_op     (alu_op),
    .alu_alt    (alu_alt),
    .reg_wen    (reg_wen),
    .dmem_write (dmem_write),
    .dmem_read  (dmem_read),
    .dmem_reg   (dmem_reg),
    .pc_imm     (pc_imm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] ins;
    logic [31:0] imm;
    logic [17:0] ctl;
    logic        ill;
  } vec_t;

  // ctl = {imm_type, alu_imm, alu_a0, alu_apc, alu_b4, alu_op,
  //        alu_alt, reg_wen, dmem_write, dmem_read, dmem_reg, pc_imm}
  function automatic vec_t mk(
    string n, logic [31:0] i, logic [31:0] im, logic [2:0] it,
    logic ai, logic a0, logic ap, logic b4, logic [2:0] op,
    logic alt, logic wen, logic dw, logic dr, logic dg,
    logic [2:0] pc, logic il);
    vec_t v;
    v.name = n;
    v.ins  = i;
    v.imm  = im;
    v.ctl  = {it, ai, a0, ap, b4, op, alt, wen, dw, dr, dg, pc};
    v.ill  = il;
    return v;
  endfunction

  function automatic logic [17:0] act_ctl();
    return {imm_type, alu_imm, alu_a0, alu_apc, alu_b4, alu_op,
            alu_alt, reg_wen, dmem_write, dmem_read, dmem_reg, pc_imm};
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp)
      passed++;
    else
      $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
  endtask

  vec_t tbl[$];

  initial begin
    //            name      ins           imm          it ai a0 ap b4 op   al we dw dr dg pc il
    tbl.push_back(mk("addi",  32'hFFF00093, 32'hFFFFFFFF, 1, 1,0,0,0, 3'd0, 0,1,0,0,0, 1, 0));
    tbl.push_back(mk("sub",   32'h402081B3, 32'h00000000, 0, 0,0,0,0, 3'd0, 1,1,0,0,0, 1, 0));
    tbl.push_back(mk("beq",   32'hFE208EE3, 32'hFFFFFFFC, 3, 0,0,0,0, 3'd0, 1,0,0,0,0, 3, 0));
    tbl.push_back(mk("sw",    32'h0020A423, 32'h00000008, 2, 1,0,0,0, 3'd0, 0,0,1,0,0, 1, 0));
    tbl.push_back(mk("lui",   32'h123452B7, 32'h12345000, 4, 1,1,0,0, 3'd0, 0,1,0,0,0, 1, 0));
    tbl.push_back(mk("auipc", 32'h00001097, 32'h00001000, 4, 1,0,1,0, 3'd0, 0,1,0,0,0, 1, 0));
    tbl.push_back(mk("jal",   32'h008000EF, 32'h00000008, 5, 0,0,1,1, 3'd0, 0,1,0,0,0, 4, 0));
    tbl.push_back(mk("jalr",  32'h000080E7, 32'h00000000, 1, 0,0,1,1, 3'd0, 0,1,0,0,0, 5, 0));
    tbl.push_back(mk("lw",    32'h0040A103, 32'h00000004, 1, 1,0,0,0, 3'd0, 0,1,0,1,1, 1, 0));
    tbl.push_back(mk("fence", 32'h0FF0000F, 32'h00000000, 0, 0,0,0,0, 3'd0, 0,0,0,0,0, 1, 0));
    tbl.push_back(mk("blt",   32'h0020C463, 32'h00000008, 3, 0,0,0,0, 3'd2, 0,0,0,0,0, 2, 0));
    tbl.push_back(mk("bgeu",  32'h0020F463, 32'h00000008, 3, 0,0,0,0, 3'd3, 0,0,0,0,0, 3, 0));
    tbl.push_back(mk("srai",  32'h4010D093, 32'h00000401, 1, 1,0,0,0, 3'd5, 1,1,0,0,0, 1, 0));
    tbl.push_back(mk("slt",   32'h0020A1B3, 32'h00000000, 0, 0,0,0,0, 3'd2, 0,1,0,0,0, 1, 0));
    tbl.push_back(mk("ecall", 32'h00000073, 32'h00000000, 0, 0,0,0,0, 3'd0, 0,0,0,0,0, 0, 1));
    tbl.push_back(mk("opf7",  32'h4020C1B3, 32'h00000000, 0, 0,0,0,0, 3'd0, 0,0,0,0,0, 0, 1));
    tbl.push_back(mk("slli7", 32'h40109093, 32'h00000401, 1, 0,0,0,0, 3'd0, 0,0,0,0,0, 0, 1));
    tbl.push_back(mk("ld",    32'h0000B083, 32'h00000000, 1, 0,0,0,0, 3'd0, 0,0,0,0,0, 0, 1));
    tbl.push_back(mk("br010", 32'h0020A063, 32'h00000000, 3, 0,0,0,0, 3'd0, 0,0,0,0,0, 0, 1));
    tbl.push_back(mk("jalr1", 32'h000090E7, 32'h00000000, 1, 0,0,0,0, 3'd0, 0,0,0,0,0, 0, 1));

    // Reset state
    reset_n = 1'b0;
    ins     = 32'h00000000;
    @(posedge clk);
    #1;
    chk("rst_flag", 32'(op_illegal), 32'd0);
    ins = 32'h0020A423;
    #1;
    chk("rst_dw",   32'(dmem_write), 32'd0);
    chk("rst_wen",  32'(reg_wen),    32'd0);
    chk("rst_pc",   32'(pc_imm),     32'd1);
    chk("rst_imm",  imm,             32'h00000008);
    chk("rst_ityp", 32'(imm_type),   32'd2);
    ins = 32'h0000B083;
    #1;
    chk("rst_rd",   32'(dmem_read),  32'd0);
    chk("rst_drg",  32'(dmem_reg),   32'd0);
    @(posedge clk);
    #1;
    chk("rst_ill_hold0", 32'(op_illegal), 32'd0);

    // Table sweep with sticky-flag model
    @(negedge clk);
    reset_n = 1'b1;
    sticky  = 1'b0;
    foreach (tbl[k]) begin
      ins = tbl[k].ins;
      #1;
      chk({tbl[k].name, "_imm"}, imm, tbl[k].imm);
      chk({tbl[k].name, "_ctl"}, 32'(act_ctl()), 32'(tbl[k].ctl));
      @(posedge clk);
      sticky = sticky | tbl[k].ill;
      #1;
      chk({tbl[k].name, "_flag"}, 32'(op_illegal), 32'(sticky));
      @(negedge clk);
    end

    // Sticky flag from all-zero word, then clear via reset
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    ins = 32'h00000000;
    #1;
    chk("zero_pc",  32'(pc_imm),     32'd0);
    chk("zero_wen", 32'(reg_wen),    32'd0);
    chk("zero_pre", 32'(op_illegal), 32'd0);
    @(posedge clk);
    #1;
    chk("zero_set", 32'(op_illegal), 32'd1);
    @(negedge clk);
    ins = 32'hFFF00093;
    repeat (3) @(posedge clk);
    #1;
    chk("zero_hold", 32'(op_illegal), 32'd1);
    chk("hold_wen",  32'(reg_wen),    32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    ins = 32'h00000000;
    #1;
    chk("clr_pre",  32'(op_illegal), 32'd1);
    @(posedge clk);
    #1;
    chk("clr_done", 32'(op_illegal), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/decode_control.md
DECODE_CONTROL -- requirements
Module: decode_control

Interface
Parameters: none.
REQ-001 clk  input  1  rising-edge clock for the op_illegal flag.
REQ-002 reset_n  input  1  synchronous, active-low reset.
REQ-003 ins  input  32  RV32I instruction word.
REQ-004 imm  output  32  sign-extended immediate.
REQ-005 imm_type  output  3  immediate format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J.
REQ-006 op_illegal  output  1  sticky illegal-instruction flag.
REQ-007 alu_imm, alu_a0, alu_apc, alu_b4  output  1 each  operand selects: B=imm, A=0, A=pc, B=4.
REQ-008 alu_op  output  3  ALU function.
REQ-009 alu_alt  output  1  selects SUB for op 000 and SRA for op 101.
REQ-010 reg_wen, dmem_write, dmem_read, dmem_reg  output  1 each  regfile write enable, store, load, writeback from memory.
REQ-011 pc_imm  output  3  next-PC mode: 0 PC_IMM_0 (hold), 1 PC_IMM_4, 2 BNZ, 3 BZ, 4 JAL, 5 JALR.

Function
REQ-012 All outputs except op_illegal SHALL be purely combinational from ins and reset_n.
REQ-013 imm_type by opcode ins[6:0]: I for 0010011, 0000011 and 1100111; S for 0100011; B for 1100011; U for 0110111 and 0010111; J for 1101111; NONE otherwise.
REQ-014 imm by format: I = sext(ins[31:20]); S = sext({ins[31:25],ins[11:7]}); B = sext({ins[31],ins[7],ins[30:25],ins[11:8],0}); U = {ins[31:12],12'h0}; J = sext({ins[31],ins[19:12],ins[20],ins[30:21],0}); NONE = 0.
REQ-015 OP (0110011): alu_op=funct3, alu_alt=ins[30], alu_imm=0, reg_wen=1, pc_imm=4; legal only if funct7=0x00, or funct7=0x20 with funct3 000/101.
REQ-016 OP-IMM (0010011): alu_op=funct3, alu_imm=1, reg_wen=1, pc_imm=4; alu_alt=ins[30] only when funct3=101, else 0; funct3 001 requires funct7=0x00; funct3 101 requires funct7 0x00 or 0x20.
REQ-017 LOAD (0000011): alu_op=000, alu_imm=1, dmem_read=1, dmem_reg=1, reg_wen=1, pc_imm=4; funct3 011/110/111 illegal.
REQ-018 STORE (0100011): alu_op=000, alu_imm=1, dmem_write=1, reg_wen=0, pc_imm=4; funct3 >= 011 illegal.
REQ-019 BRANCH (1100011): reg_wen=0, alu_imm=0; BEQ: op 000 alt=1, pc_imm BZ; BNE: op 000 alt=1, BNZ; BLT: op 010, BNZ; BGE: op 010, BZ; BLTU: op 011, BNZ; BGEU: op 011, BZ; funct3 010/011 illegal.
REQ-020 LUI: alu_a0=1, alu_imm=1, op 000, reg_wen=1, pc_imm=4. AUIPC: alu_apc=1, alu_imm=1, op 000, reg_wen=1, pc_imm=4.
REQ-021 JAL: alu_apc=1, alu_b4=1, op 000, reg_wen=1, pc_imm=JAL. JALR: same operand selects, pc_imm=JALR, funct3 != 000 illegal.
REQ-022 MISC-MEM (0001111): legal NOP, all enables 0, pc_imm=4.
REQ-023 Any other opcode (including SYSTEM), or any illegal funct combination, is illegal.
REQ-024 Illegal instruction: reg_wen=0, dmem_write=0, dmem_read=0, pc_imm=PC_IMM_0.
REQ-025 Unlisted outputs SHALL be 0; alu_a0 takes priority over alu_apc, and alu_b4 over alu_imm.
REQ-026 op_illegal SHALL be set on the rising clk edge on which an illegal instruction is decoded and reset_n=1, then hold until reset.

Reset
REQ-027 While reset_n=0: reg_wen, dmem_write, dmem_read and dmem_reg SHALL be 0 and pc_imm=PC_IMM_4 combinationally, regardless of ins.
REQ-028 A rising clk edge with reset_n=0 SHALL clear op_illegal; the reset value of op_illegal is 0.
REQ-029 imm and imm_type SHALL follow ins during reset.

Verification
REQ-030 ins=0xFFF00093 (addi x1,x0,-1) -> imm=0xFFFFFFFF, imm_type=1, alu_imm=1, alu_op=000, alu_alt=0, reg_wen=1, pc_imm=1.
REQ-031 ins=0x402081B3 (sub) -> alu_alt=1, alu_imm=0, alu_op=000, reg_wen=1, imm_type=0, imm=0.
REQ-032 ins=0xFE208EE3 (beq x1,x2,-4) -> imm=0xFFFFFFFC, imm_type=3, alu_alt=1, pc_imm=3, reg_wen=0.
REQ-033 ins=0x0020A423 (sw x2,8(x1)) -> imm=0x00000008, imm_type=2, dmem_write=1, alu_imm=1, reg_wen=0; then ins=0x123452B7 (lui) -> imm=0x12345000, alu_a0=1, reg_wen=1.
REQ-034 ins=0x00000000, one clk edge with reset_n=1 -> pc_imm=0, reg_wen=0, op_illegal=1 and held through later legal instructions; a clk edge with reset_n=0 -> op_illegal=0.
REQ-035 reset_n=0 with ins=0x0020A423 -> dmem_write=0, reg_wen=0, pc_imm=1, imm=0x00000008.
